// File: rtl/keypad_encoder.sv
// Keypad front end: synchronizer, whole-vector debouncer, note priority encoder
// and rising-edge pulses for the mode and sound-series keys. Debouncer is built only when KEYPAD_DEBOUNCE_EN is defined.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [14:0] keypad_i,
  output logic [3:0]  keycode,
  output logic        mode_key,
  output logic        sound_edge
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("keypad_encoder: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [14:0] sync1;
  logic [14:0] sync2;
  logic [14:0] stable;
  logic        prev13;
  logic        prev14;
  logic [3:0]  code_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keypad_i;
      sync2 <= sync1;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [14:0]      cand;
  logic [CNT_W-1:0] cnt;

  // Any bit change restarts the window; the counter saturates while the input is steady.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= cand;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stable <= '0;
    end else begin
      stable <= sync2;
    end
  end
`endif

  // Lowest-numbered held note wins; the loop runs downward so the lowest index assigns last.
  always_comb begin
    code_next = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (stable[i]) begin
        code_next = 4'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      keycode    <= 4'd0;
      prev13     <= 1'b0;
      prev14     <= 1'b0;
      mode_key   <= 1'b0;
      sound_edge <= 1'b0;
    end else begin
      keycode    <= code_next;
      prev13     <= stable[13];
      prev14     <= stable[14];
      mode_key   <= stable[13] & ~prev13;
      sound_edge <= stable[14] & ~prev14;
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder with DEBOUNCE_CYCLES=4; a window-based reference
// model predicts outputs in both the debounced and the bypass build.
module tb_keypad_encoder;

  localparam int D = 4;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int WIN = D + 1;
  localparam int LAT = D + 3;
`else
  localparam int WIN = 1;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [14:0] keypad_i = '0;
  logic [3:0]  keycode;
  logic        mode_key;
  logic        sound_edge;

  int assert_count = 0;
  int fail_count = 0;

  logic [14:0] hist[$];
  logic [14:0] m_stable;
  logic [14:0] m_stable_old;
  logic [3:0]  m_code;
  logic        m_mode;
  logic        m_sound;

  keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .keypad_i   (keypad_i),
    .keycode    (keycode),
    .mode_key   (mode_key),
    .sound_edge (sound_edge)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] encode(input logic [14:0] s);
    for (int i = 0; i < 13; i++) begin
      if (s[i]) return 4'(i + 1);
    end
    return 4'd0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < WIN + 2; i++) hist.push_back('0);
    m_stable = '0;
    m_stable_old = '0;
    m_code = '0;
    m_mode = 1'b0;
    m_sound = 1'b0;
  endtask

  // The debounced state becomes v once the last WIN synchronized samples all equal v.
  task automatic model_edge(input logic [14:0] sample);
    int n;
    logic [14:0] v;
    bit same;
    m_code  = encode(m_stable);
    m_mode  = m_stable[13] & ~m_stable_old[13];
    m_sound = m_stable[14] & ~m_stable_old[14];
    hist.push_back(sample);
    n = hist.size();
    v = hist[n-3];
    same = 1'b1;
    for (int j = 0; j < WIN; j++) begin
      if (hist[n-3-j] != v) same = 1'b0;
    end
    m_stable_old = m_stable;
    if (same) m_stable = v;
    if (hist.size() > 64) void'(hist.pop_front());
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".keycode"}, int'(keycode), int'(m_code));
    chk({tag, ".mode_key"}, int'(mode_key), int'(m_mode));
    chk({tag, ".sound_edge"}, int'(sound_edge), int'(m_sound));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(keypad_i);
    #1;
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic [14:0] v, input int cycles, input string tag);
    keypad_i = v;
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    int cnt_c;
    int found;
    model_reset();

    // Reset held with every button pressed.
    n_rst = 1'b0;
    keypad_i = 15'h7FFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("reset.keycode", int'(keycode), 0);
      chk("reset.mode_key", int'(mode_key), 0);
      chk("reset.sound_edge", int'(sound_edge), 0);
    end
    @(negedge clk);
    keypad_i = '0;
    n_rst = 1'b1;
    model_reset();
    applyStimulus('0, LAT + 2, "idle");

    // Single note: code appears on the edge LAT after capture (tick LAT+1).
    keypad_i = 15'h0010;
    for (int i = 0; i < LAT; i++) tick("note_hold");
    chk("note.before_latency", int'(keycode), 0);
    tick("note_hold");
    chk("note.at_latency", int'(keycode), 5);
    applyStimulus(15'h0010, 4, "note_hold");
    keypad_i = '0;
    for (int i = 0; i < LAT; i++) tick("note_release");
    chk("release.before_latency", int'(keycode), 5);
    tick("note_release");
    chk("release.at_latency", int'(keycode), 0);
    applyStimulus('0, 3, "idle");

    // Three-cycle glitch on note 0.
    cnt_a = 0;
    keypad_i = 15'h0001;
    for (int i = 0; i < 3; i++) begin
      tick("glitch");
      if (keycode != 0) cnt_a++;
    end
    keypad_i = '0;
    for (int i = 0; i < 12; i++) begin
      tick("glitch");
      if (keycode != 0) cnt_a++;
    end
    chk("glitch.nonzero_cycles", cnt_a, (WIN == 1) ? 3 : 0);

    // Two notes together: lowest index wins.
    applyStimulus(15'h0003, LAT + 1, "two_notes");
    chk("two_notes.keycode", int'(keycode), 1);
    applyStimulus('0, LAT + 2, "idle");

    // Mode and sound together: exactly one coincident pulse, none on release.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    keypad_i = 15'h6000;
    for (int i = 0; i < 50; i++) begin
      tick("mode_sound");
      if (mode_key) cnt_a++;
      if (sound_edge) cnt_b++;
      if (mode_key && sound_edge) cnt_c++;
    end
    chk("mode_sound.mode_pulses", cnt_a, 1);
    chk("mode_sound.sound_pulses", cnt_b, 1);
    chk("mode_sound.together", cnt_c, 1);
    cnt_a = 0;
    keypad_i = '0;
    for (int i = 0; i < 20; i++) begin
      tick("mode_release");
      if (mode_key || sound_edge) cnt_a++;
    end
    chk("mode_release.pulses", cnt_a, 0);

    // Reset while the mode pulse is visible.
    found = 0;
    keypad_i = 15'h2001;
    for (int i = 0; i < 40 && found == 0; i++) begin
      tick("pre_reset");
      if (m_mode) found = 1;
    end
    chk("pre_reset.pulse_seen", int'(mode_key), 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_reset.keycode", int'(keycode), 0);
    chk("async_reset.mode_key", int'(mode_key), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset.keycode", int'(keycode), 0);
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    found = 0;
    cnt_a = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      tick("post_reset");
      if (mode_key) begin
        cnt_a++;
        if (found == 0) found = i;
      end
    end
    chk("post_reset.pulse_tick", found, LAT + 1);
    chk("post_reset.pulse_count", cnt_a, 1);
    applyStimulus('0, LAT + 2, "idle");

    // One-cycle press of note 12.
    cnt_a = 0;
    keypad_i = 15'h1000;
    tick("short_note");
    if (keycode == 4'd13) cnt_a++;
    keypad_i = '0;
    for (int i = 0; i < 12; i++) begin
      tick("short_note");
      if (keycode == 4'd13) cnt_a++;
    end
    chk("short_note.code13_cycles", cnt_a, (WIN == 1) ? 1 : 0);

    // Randomized hold lengths straddling the debounce window.
    for (int s = 0; s < 80; s++) begin
      logic [14:0] v;
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = 15'(1 << $urandom_range(0, 14));
        2: v = 15'($urandom);
        default: v = 15'($urandom) & 15'h6000;
      endcase
      applyStimulus(v, $urandom_range(1, WIN + 4), "random");
    end
    applyStimulus('0, LAT + 2, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
